// File: rtl/placement_pkg.sv
// Shared constants and state encoding for the post-placement checker.
package placement_pkg;

  // Marker used in position and grid RAMs for "nothing here".
  localparam int EMPTY = -1;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_UNPLACED = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_GRID     = 3'd3;
  localparam logic [2:0] ERR_OCC_POS  = 3'd4;
  localparam logic [2:0] ERR_OCC_ID   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_NODE_RD, S_NODE_CHK, S_NODE_GRID,
    S_GRID_RD, S_GRID_CHK, S_GRID_POS,
    S_EDGE_RD, S_EDGE_A, S_EDGE_B, S_EDGE_ACC,
    S_DONE
  } chk_state_t;

endpackage

// File: rtl/manhattan_cost.sv
// Per-edge cost: Manhattan distance minus one, and the same with
// two-cell hops (each axis distance rounded up to half). Wraps, no saturation.
module manhattan_cost #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] xa,
  input  logic [DW-1:0] ya,
  input  logic [DW-1:0] xb,
  input  logic [DW-1:0] yb,
  output logic [DW-1:0] cost,
  output logic [DW-1:0] cost_1hop
);

  logic [DW-1:0] ddx, ddy, dx, dy, hx, hy;

  // Absolute axis distances and their rounded-up halves.
  always_comb begin
    ddx       = xa - xb;
    ddy       = ya - yb;
    dx        = ddx[DW-1] ? -ddx : ddx;
    dy        = ddy[DW-1] ? -ddy : ddy;
    hx        = (dx >> 1) + {{(DW-1){1'b0}}, dx[0]};
    hy        = (dy >> 1) + {{(DW-1){1'b0}}, dy[0]};
    cost      = dx + dy - DW'(1);
    cost_1hop = hx + hy - DW'(1);
  end

endmodule

// File: rtl/placement_checker.sv
// Post-placement checker: node->grid consistency, grid->node consistency,
// then wirelength over the edge list. Borrows the placer's memory ports.
module placement_checker
  import placement_pkg::*;
#(
  parameter int GRID_N  = 6,
  parameter int N_NODES = 32,
  parameter int N_EDGE  = 32,
  parameter int DW      = 32,
  parameter int GRID_AW = 6,
  parameter int POS_AW  = 7,
  parameter int EDGE_AW = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_code,
  output logic [DW-1:0]      err_index,
  output logic [DW-1:0]      wirelength,
  output logic [DW-1:0]      wirelength_1hop,
  output logic [DW-1:0]      occupied,
  output logic               pos_re,
  output logic [POS_AW-1:0]  pos_addr,
  input  logic [DW-1:0]      pos_x_data,
  input  logic [DW-1:0]      pos_y_data,
  output logic               grid_re,
  output logic [GRID_AW-1:0] grid_addr,
  input  logic [DW-1:0]      grid_data,
  output logic               edge_re,
  output logic [EDGE_AW-1:0] edge_addr,
  input  logic [DW-1:0]      edge_a,
  input  logic [DW-1:0]      edge_b
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam logic [DW-1:0] EMPTY_W = DW'(EMPTY);
  localparam logic signed [DW-1:0] GRID_S  = DW'(GRID_N);
  localparam logic signed [DW-1:0] NODES_S = DW'(N_NODES);

  chk_state_t state;
  logic [POS_AW-1:0]  node_idx, node_b;
  logic [GRID_AW-1:0] cell_idx;
  logic [EDGE_AW-1:0] edge_idx;
  logic [DW-1:0]      xa, ya, cost, cost_1hop, pos_cell;
  logic signed [DW-1:0] px, py, gd;
  logic pos_unplaced, pos_out, id_bad, grid_empty;
  logic node_last, cell_last, edge_last;
  logic err_hit;
  logic [2:0] err_c;
  logic [DW-1:0] err_i;
  logic unused_hi;

  assign px = pos_x_data;
  assign py = pos_y_data;
  assign gd = grid_data;
  assign pos_cell     = pos_x_data * DW'(GRID_N) + pos_y_data;
  assign pos_unplaced = (pos_x_data == EMPTY_W) || (pos_y_data == EMPTY_W);
  assign pos_out      = px[DW-1] || (px >= GRID_S) || py[DW-1] || (py >= GRID_S);
  assign grid_empty   = (grid_data == EMPTY_W);
  assign id_bad       = gd[DW-1] || (gd >= NODES_S);
  assign node_last    = (node_idx == POS_AW'(N_NODES - 1));
  assign cell_last    = (cell_idx == GRID_AW'(CELLS - 1));
  assign edge_last    = (edge_idx == EDGE_AW'(N_EDGE - 1));
  // Edge endpoints only address the position RAM; upper bits are don't-care.
  assign unused_hi    = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW]};

  manhattan_cost #(.DW(DW)) u_cost (
    .xa(xa), .ya(ya), .xb(pos_x_data), .yb(pos_y_data),
    .cost(cost), .cost_1hop(cost_1hop)
  );

  // Read strobes are decoded from state so a dependent read can be issued
  // in the same cycle its address data arrives (keeps the 3-cycle node step).
  always_comb begin
    pos_re = 1'b0; pos_addr = '0;
    grid_re = 1'b0; grid_addr = '0;
    edge_re = 1'b0; edge_addr = '0;
    if (!reset) begin
      case (state)
        S_NODE_RD:  begin pos_re = 1'b1; pos_addr = node_idx; end
        S_NODE_CHK: if (!pos_unplaced && !pos_out) begin
                      grid_re = 1'b1; grid_addr = GRID_AW'(pos_cell);
                    end
        S_GRID_RD:  begin grid_re = 1'b1; grid_addr = cell_idx; end
        S_GRID_CHK: if (!grid_empty && !id_bad) begin
                      pos_re = 1'b1; pos_addr = POS_AW'(grid_data);
                    end
        S_EDGE_RD:  begin edge_re = 1'b1; edge_addr = edge_idx; end
        S_EDGE_A:   begin pos_re = 1'b1; pos_addr = POS_AW'(edge_a); end
        S_EDGE_B:   begin pos_re = 1'b1; pos_addr = node_b; end
        default: ;
      endcase
    end
  end

  // Error detection for the current check step.
  always_comb begin
    err_hit = 1'b0; err_c = ERR_NONE; err_i = '0;
    case (state)
      S_NODE_CHK:
        if (pos_unplaced) begin
          err_hit = 1'b1; err_c = ERR_UNPLACED; err_i = DW'(node_idx);
        end else if (pos_out) begin
          err_hit = 1'b1; err_c = ERR_RANGE; err_i = DW'(node_idx);
        end
      S_NODE_GRID:
        if (grid_data != DW'(node_idx)) begin
          err_hit = 1'b1; err_c = ERR_GRID; err_i = DW'(node_idx);
        end
      S_GRID_CHK:
        if (!grid_empty && id_bad) begin
          err_hit = 1'b1; err_c = ERR_OCC_ID; err_i = DW'(cell_idx);
        end
      S_GRID_POS:
        if (pos_cell != DW'(cell_idx)) begin
          err_hit = 1'b1; err_c = ERR_OCC_POS; err_i = DW'(cell_idx);
        end
      default: ;
    endcase
  end

  // Main FSM: walk nodes, then cells, then edges; first error ends the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
      err_code <= ERR_NONE; err_index <= '0;
      wirelength <= '0; wirelength_1hop <= '0; occupied <= '0;
      node_idx <= '0; cell_idx <= '0; edge_idx <= '0;
      node_b <= '0; xa <= '0; ya <= '0;
    end else begin
      done <= 1'b0;
      if (err_hit) begin
        err_code <= err_c; err_index <= err_i;
        pass <= 1'b0; busy <= 1'b0; done <= 1'b1;
        state <= S_DONE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            busy <= 1'b1; pass <= 1'b0;
            err_code <= ERR_NONE; err_index <= '0;
            wirelength <= '0; wirelength_1hop <= '0; occupied <= '0;
            node_idx <= '0; cell_idx <= '0; edge_idx <= '0;
            state <= S_NODE_RD;
          end
          S_NODE_RD:  state <= S_NODE_CHK;
          S_NODE_CHK: state <= S_NODE_GRID;
          S_NODE_GRID:
            if (node_last) state <= S_GRID_RD;
            else begin node_idx <= node_idx + POS_AW'(1); state <= S_NODE_RD; end
          S_GRID_RD: state <= S_GRID_CHK;
          S_GRID_CHK:
            if (!grid_empty) begin
              occupied <= occupied + DW'(1); state <= S_GRID_POS;
            end else if (cell_last) state <= S_EDGE_RD;
            else begin cell_idx <= cell_idx + GRID_AW'(1); state <= S_GRID_RD; end
          S_GRID_POS:
            if (cell_last) state <= S_EDGE_RD;
            else begin cell_idx <= cell_idx + GRID_AW'(1); state <= S_GRID_RD; end
          S_EDGE_RD: state <= S_EDGE_A;
          S_EDGE_A: begin node_b <= POS_AW'(edge_b); state <= S_EDGE_B; end
          S_EDGE_B: begin xa <= pos_x_data; ya <= pos_y_data; state <= S_EDGE_ACC; end
          S_EDGE_ACC: begin
            wirelength <= wirelength + cost;
            wirelength_1hop <= wirelength_1hop + cost_1hop;
            if (edge_last) begin
              pass <= 1'b1; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
            end else begin
              edge_idx <= edge_idx + EDGE_AW'(1); state <= S_EDGE_RD;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_placement_checker.sv
// Bench for placement_checker on a 3x3 grid, 4 nodes, 3 edges.
module tb_placement_checker;
  localparam int G = 3, NN = 4, NE = 3, DW = 32, GAW = 6, PAW = 7, EAW = 7;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, pass;
  logic [2:0] err_code;
  logic [DW-1:0] err_index, wirelength, wirelength_1hop, occupied;
  logic pos_re, grid_re, edge_re;
  logic [PAW-1:0] pos_addr;
  logic [GAW-1:0] grid_addr;
  logic [EAW-1:0] edge_addr;
  logic [DW-1:0] pos_x_data, pos_y_data, grid_data, edge_a, edge_b;

  always #5 clk = ~clk;

  placement_checker #(.GRID_N(G), .N_NODES(NN), .N_EDGE(NE), .DW(DW),
                      .GRID_AW(GAW), .POS_AW(PAW), .EDGE_AW(EAW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .err_index(err_index), .wirelength(wirelength),
    .wirelength_1hop(wirelength_1hop), .occupied(occupied),
    .pos_re(pos_re), .pos_addr(pos_addr), .pos_x_data(pos_x_data), .pos_y_data(pos_y_data),
    .grid_re(grid_re), .grid_addr(grid_addr), .grid_data(grid_data),
    .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b));

  // Memory models: 1-cycle latency, garbage when not read.
  logic [DW-1:0] pos_x_m [128], pos_y_m [128], grid_m [64], ea_m [128], eb_m [128];
  always @(posedge clk) begin
    pos_x_data <= pos_re  ? pos_x_m[pos_addr] : 32'hA5A5_A5A5;
    pos_y_data <= pos_re  ? pos_y_m[pos_addr] : 32'h5A5A_5A5A;
    grid_data  <= grid_re ? grid_m[grid_addr] : 32'hA5A5_A5A5;
    edge_a     <= edge_re ? ea_m[edge_addr]   : 32'h0000_0055;
    edge_b     <= edge_re ? eb_m[edge_addr]   : 32'h0000_0066;
  end

  typedef struct { int pass_, code, idx, wl, wl1, occ, lat, edges; } exp_t;
  typedef struct { int sel, addr, val; string name; exp_t e; } vec_t;

  int checks = 0, passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(int p, int c, int i, int wl, int wl1, int occ, int lat, int ed);
    exp_t e;
    e.pass_ = p; e.code = c; e.idx = i; e.wl = wl; e.wl1 = wl1;
    e.occ = occ; e.lat = lat; e.edges = ed;
    return e;
  endfunction

  function automatic vec_t mv(int sel, int addr, int val, string name, exp_t e);
    vec_t v;
    v.sel = sel; v.addr = addr; v.val = val; v.name = name; v.e = e;
    return v;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      pos_x_m[i] = '1; pos_y_m[i] = '1; ea_m[i] = '0; eb_m[i] = '0;
    end
    for (int i = 0; i < 64; i++) grid_m[i] = '1;
  endtask

  task automatic place(input int n, input int x, input int y);
    pos_x_m[n] = x; pos_y_m[n] = y; grid_m[x * G + y] = n;
  endtask

  task automatic load_base();
    clear_mem();
    place(0, 0, 0); place(1, 0, 1); place(2, 2, 2); place(3, 1, 0);
    ea_m[0] = 0; eb_m[0] = 1;
    ea_m[1] = 1; eb_m[1] = 2;
    ea_m[2] = 0; eb_m[2] = 3;
  endtask

  task automatic patch(input int sel, input int addr, input int val);
    case (sel)
      1: pos_x_m[addr] = val;
      2: pos_y_m[addr] = val;
      3: grid_m[addr] = val;
      default: ;
    endcase
  endtask

  // Reference: apply the checking rules directly, tallying cycle cost per step.
  function automatic exp_t model();
    exp_t e;
    int x, y, g, code, idx, lat, occ, wl, wl1, ed, xa, ya, xb, yb, dx, dy;
    code = 0; idx = 0; lat = 0; occ = 0; wl = 0; wl1 = 0; ed = 0;
    for (int v = 0; v < NN && code == 0; v++) begin
      x = $signed(pos_x_m[v]); y = $signed(pos_y_m[v]); lat += 2;
      if (x == -1 || y == -1) begin code = 1; idx = v; end
      else if (x < 0 || x >= G || y < 0 || y >= G) begin code = 2; idx = v; end
      else begin
        lat += 1;
        if ($signed(grid_m[x * G + y]) != v) begin code = 3; idx = v; end
      end
    end
    for (int c = 0; c < G * G && code == 0; c++) begin
      lat += 2; g = $signed(grid_m[c]);
      if (g != -1) begin
        if (g < 0 || g >= NN) begin code = 5; idx = c; end
        else begin
          occ++; lat += 1;
          if ($signed(pos_x_m[g]) * G + $signed(pos_y_m[g]) != c) begin code = 4; idx = c; end
        end
      end
    end
    if (code == 0)
      for (int k = 0; k < NE; k++) begin
        lat += 4; ed++;
        xa = $signed(pos_x_m[ea_m[k]]); ya = $signed(pos_y_m[ea_m[k]]);
        xb = $signed(pos_x_m[eb_m[k]]); yb = $signed(pos_y_m[eb_m[k]]);
        dx = (xa > xb) ? xa - xb : xb - xa;
        dy = (ya > yb) ? ya - yb : yb - ya;
        wl  += dx + dy - 1;
        wl1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
      end
    lat += 1;
    return mk(code == 0, code, idx, wl, wl1, occ, lat, ed);
  endfunction

  // Pulse start, optionally re-pulse start at cycle inj while busy, wait for done.
  task automatic do_run(input int inj, output int lat, output int edges,
                        output logic busy1, output logic ok);
    lat = 0; edges = 0; busy1 = 1'b0; ok = 1'b0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == 1) busy1 = busy;
      if (edge_re) edges++;
      if (done) begin lat = k; ok = 1'b1; break; end
      start = (k == inj);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string n, input exp_t e, input int inj);
    int lat, edges; logic busy1, ok;
    do_run(inj, lat, edges, busy1, ok);
    chk({n, ".done_seen"}, ok, 1);
    if (ok) begin
      chk({n, ".busy_after_start"}, busy1, 1);
      chk({n, ".latency"}, lat, e.lat);
      chk({n, ".edge_reads"}, edges, e.edges);
      chk({n, ".busy_at_done"}, busy, 0);
      chk({n, ".pass"}, pass, e.pass_);
      chk({n, ".err_code"}, err_code, e.code);
      chk({n, ".err_index"}, $signed(err_index), e.idx);
      chk({n, ".wirelength"}, $signed(wirelength), e.wl);
      chk({n, ".wirelength_1hop"}, $signed(wirelength_1hop), e.wl1);
      chk({n, ".occupied"}, $signed(occupied), e.occ);
      @(posedge clk); #1;
      chk({n, ".done_pulse_1cyc"}, done, 0);
      chk({n, ".pass_held"}, pass, e.pass_);
      chk({n, ".code_held"}, err_code, e.code);
    end
  endtask

  vec_t tbl [9];

  initial begin
    int nd, perm[9], t, sel;
    exp_t e;

    tbl[0] = mv(0, 0, 0,  "clean",     mk(1, 0, 0, 2, 1, 4, 47, 3));
    tbl[1] = mv(1, 2, -1, "posx2_m1",  mk(0, 1, 2, 0, 0, 0, 9, 0));
    tbl[2] = mv(3, 8, 1,  "grid8_1",   mk(0, 3, 2, 0, 0, 0, 10, 0));
    tbl[3] = mv(3, 4, 0,  "grid4_dup", mk(0, 4, 4, 0, 0, 4, 27, 0));
    tbl[4] = mv(3, 5, 9,  "grid5_9",   mk(0, 5, 5, 0, 0, 3, 28, 0));
    tbl[5] = mv(2, 3, 3,  "posy3_3",   mk(0, 2, 3, 0, 0, 0, 12, 0));
    tbl[6] = mv(1, 1, -5, "posx1_m5",  mk(0, 2, 1, 0, 0, 0, 6, 0));
    tbl[7] = mv(3, 0, -1, "grid0_emp", mk(0, 3, 0, 0, 0, 0, 4, 0));
    tbl[8] = mv(3, 2, -2, "grid2_m2",  mk(0, 5, 2, 0, 0, 2, 21, 0));

    load_base();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);       chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);       chk("rst.err_code", err_code, 0);
    chk("rst.err_index", err_index, 0);
    chk("rst.wl", wirelength, 0);   chk("rst.wl1", wirelength_1hop, 0);
    chk("rst.occupied", occupied, 0);
    chk("rst.re", {pos_re, grid_re, edge_re}, 0);
    chk("rst.addr", {pos_addr, grid_addr, edge_addr}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      load_base();
      patch(tbl[i].sel, tbl[i].addr, tbl[i].val);
      run_check(tbl[i].name, tbl[i].e, 0);
    end

    // Start re-pulsed while busy must not disturb the run.
    load_base();
    run_check("start_while_busy", tbl[0].e, 10);

    // Reset in the middle of the grid walk: abort, no done pulse.
    load_base();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("mid.busy_before_reset", busy, 1);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("mid.busy_after_reset", busy, 0);
    chk("mid.done_after_reset", done, 0);
    chk("mid.re_after_reset", {pos_re, grid_re, edge_re}, 0);
    nd = 0;
    repeat (60) begin @(posedge clk); #1; if (done || busy) nd++; end
    chk("mid.stays_idle", nd, 0);
    run_check("rerun", tbl[0].e, 0);

    // Random placements with occasional injected faults vs reference.
    for (int r = 0; r < 24; r++) begin
      clear_mem();
      for (int i = 0; i < 9; i++) perm[i] = i;
      for (int i = 8; i > 0; i--) begin
        int j;
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int n = 0; n < NN; n++) place(n, perm[n] / G, perm[n] % G);
      for (int k = 0; k < NE; k++) begin
        ea_m[k] = $urandom_range(0, NN - 1); eb_m[k] = $urandom_range(0, NN - 1);
      end
      sel = $urandom_range(0, 5);
      case (sel)
        2: patch(1, $urandom_range(0, NN - 1), int'($urandom_range(0, 4)) - 1);
        3: patch(2, $urandom_range(0, NN - 1), int'($urandom_range(0, 4)) - 1);
        4: patch(3, $urandom_range(0, 8), int'($urandom_range(0, 7)) - 2);
        default: ;
      endcase
      e = model();
      run_check($sformatf("rand%0d", r), e, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
